// File: rtl/cmac_dot_engine.sv
// Pipelined complex multiply-accumulate dot-product engine with optional conjugation
// of the second operand, saturating output conversion and an overflow flag.
module cmac_dot_engine #(
  parameter int NBIT  = 32,
  parameter int NFRAC = 27,
  parameter int OBIT  = 32,
  parameter int OFRAC = 21,
  parameter int NLEN  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NLEN-1:0] len,
  input  logic            conj,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] a_re,
  input  logic [NBIT-1:0] a_im,
  input  logic [NBIT-1:0] b_re,
  input  logic [NBIT-1:0] b_im,
  output logic            out_valid,
  output logic [OBIT-1:0] out_re,
  output logic [OBIT-1:0] out_im,
  output logic            ovf,
  output logic            busy
);

  localparam int PW = 2 * NBIT;
  localparam int AW = 2 * NBIT + NLEN + 1;
  localparam int SH = 2 * NFRAC - OFRAC;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [NLEN-1:0]        cnt_q, cnt_d;
  logic [NLEN-1:0]        len_q, len_d;
  logic                   conj_q, conj_d;
  logic                   drain_q, drain_d;
  logic [NBIT-1:0]        ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic                   op_vld_q, op_vld_d;
  logic signed [PW-1:0]   pp_rr_q, pp_rr_d, pp_ii_q, pp_ii_d;
  logic signed [PW-1:0]   pp_ir_q, pp_ir_d, pp_ri_q, pp_ri_d;
  logic                   p_vld_q, p_vld_d;
  logic signed [AW-1:0]   acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [OBIT-1:0]        out_re_q, out_re_d, out_im_q, out_im_d;
  logic                   ovf_q, ovf_d;
  logic                   out_valid_q, out_valid_d;

  logic                   hs;
  logic signed [AW-1:0]   rr_x, ii_x, ir_x, ri_x, re_term, im_term;
  logic signed [AW-1:0]   sh_re, sh_im;
  logic                   clip_re, clip_im;
  logic [OBIT-1:0]        sat_re, sat_im;

  assign in_ready  = (state_q == S_LOAD);
  assign hs        = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE) || out_valid_q;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign ovf       = ovf_q;

  // Products sign-extend to AW so the accumulator can never wrap over 2^NLEN terms.
  always_comb begin
    rr_x    = $signed({{(AW-PW){pp_rr_q[PW-1]}}, pp_rr_q});
    ii_x    = $signed({{(AW-PW){pp_ii_q[PW-1]}}, pp_ii_q});
    ir_x    = $signed({{(AW-PW){pp_ir_q[PW-1]}}, pp_ir_q});
    ri_x    = $signed({{(AW-PW){pp_ri_q[PW-1]}}, pp_ri_q});
    re_term = conj_q ? (rr_x + ii_x) : (rr_x - ii_x);
    im_term = conj_q ? (ir_x - ri_x) : (ir_x + ri_x);
  end

  // Shift truncates toward -inf; a value fits OBIT when all bits above the sign agree.
  always_comb begin
    sh_re   = acc_re_q >>> SH;
    sh_im   = acc_im_q >>> SH;
    clip_re = !((&sh_re[AW-1:OBIT-1]) || !(|sh_re[AW-1:OBIT-1]));
    clip_im = !((&sh_im[AW-1:OBIT-1]) || !(|sh_im[AW-1:OBIT-1]));
    sat_re  = sh_re[OBIT-1:0];
    sat_im  = sh_im[OBIT-1:0];
    if (clip_re) sat_re = sh_re[AW-1] ? {1'b1, {(OBIT-1){1'b0}}} : {1'b0, {(OBIT-1){1'b1}}};
    if (clip_im) sat_im = sh_im[AW-1] ? {1'b1, {(OBIT-1){1'b0}}} : {1'b0, {(OBIT-1){1'b1}}};
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path through this block infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    conj_d      = conj_q;
    drain_d     = drain_q;
    ar_d        = ar_q;
    ai_d        = ai_q;
    br_d        = br_q;
    bi_d        = bi_q;
    op_vld_d    = hs;
    pp_rr_d     = pp_rr_q;
    pp_ii_d     = pp_ii_q;
    pp_ir_d     = pp_ir_q;
    pp_ri_d     = pp_ri_q;
    p_vld_d     = op_vld_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;

    if (hs) begin
      ar_d = a_re;
      ai_d = a_im;
      br_d = b_re;
      bi_d = b_im;
    end

    if (op_vld_q) begin
      pp_rr_d = $signed({{NBIT{ar_q[NBIT-1]}}, ar_q}) * $signed({{NBIT{br_q[NBIT-1]}}, br_q});
      pp_ii_d = $signed({{NBIT{ai_q[NBIT-1]}}, ai_q}) * $signed({{NBIT{bi_q[NBIT-1]}}, bi_q});
      pp_ir_d = $signed({{NBIT{ai_q[NBIT-1]}}, ai_q}) * $signed({{NBIT{br_q[NBIT-1]}}, br_q});
      pp_ri_d = $signed({{NBIT{ar_q[NBIT-1]}}, ar_q}) * $signed({{NBIT{bi_q[NBIT-1]}}, bi_q});
    end

    if (p_vld_q) begin
      acc_re_d = acc_re_q + re_term;
      acc_im_d = acc_im_q + im_term;
    end

    case (state_q)
      S_IDLE: begin
        // The out_valid cycle still counts as busy, so a start there is dropped.
        if (start && !out_valid_q) begin
          state_d  = S_LOAD;
          len_d    = len;
          conj_d   = conj;
          cnt_d    = '0;
          acc_re_d = '0;
          acc_im_d = '0;
          ovf_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (hs) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_OUT;
        else         drain_d = 1'b1;
      end
      S_OUT: begin
        state_d     = S_IDLE;
        out_re_d    = sat_re;
        out_im_d    = sat_im;
        ovf_d       = clip_re || clip_im;
        out_valid_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      conj_q      <= 1'b0;
      drain_q     <= 1'b0;
      ar_q        <= '0;
      ai_q        <= '0;
      br_q        <= '0;
      bi_q        <= '0;
      op_vld_q    <= 1'b0;
      pp_rr_q     <= '0;
      pp_ii_q     <= '0;
      pp_ir_q     <= '0;
      pp_ri_q     <= '0;
      p_vld_q     <= 1'b0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      conj_q      <= conj_d;
      drain_q     <= drain_d;
      ar_q        <= ar_d;
      ai_q        <= ai_d;
      br_q        <= br_d;
      bi_q        <= bi_d;
      op_vld_q    <= op_vld_d;
      pp_rr_q     <= pp_rr_d;
      pp_ii_q     <= pp_ii_d;
      pp_ir_q     <= pp_ir_d;
      pp_ri_q     <= pp_ri_d;
      p_vld_q     <= p_vld_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_cmac_dot_engine.sv
// Directed bench for cmac_dot_engine: a plain-arithmetic dot-product model feeds a
// scoreboard checked on every out_valid, plus literal expectations for key vectors.
module tb_cmac_dot_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  len = '0;
  logic        conj = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic        out_valid;
  logic [31:0] out_re, out_im;
  logic        ovf;
  logic        busy;

  cmac_dot_engine dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .conj(conj),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic        ovf;
  } res_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  res_t prev_exp = '{re: 32'h0, im: 32'h0, ovf: 1'b0};
  logic prev_ov  = 1'b0;

  logic [31:0] va_re[16], va_im[16], vb_re[16], vb_im[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Exact complex dot product in wide integers, then floor-scale by 2^33 and clip.
  function automatic res_t model(input int n_len, input bit cj);
    logic signed [127:0] sre, sim, ar, ai, br, bi, q;
    logic signed [127:0] maxv, minv;
    res_t r;
    maxv = 128'sd2147483647;
    minv = -128'sd2147483648;
    sre = '0;
    sim = '0;
    for (int i = 0; i <= n_len; i++) begin
      ar = $signed(va_re[i]);
      ai = $signed(va_im[i]);
      br = $signed(vb_re[i]);
      bi = $signed(vb_im[i]);
      if (cj) begin
        sre = sre + ar * br + ai * bi;
        sim = sim + ai * br - ar * bi;
      end else begin
        sre = sre + ar * br - ai * bi;
        sim = sim + ai * br + ar * bi;
      end
    end
    r.ovf = 1'b0;
    q = sre >>> 33;
    if (q > maxv)      begin r.re = 32'h7FFF_FFFF; r.ovf = 1'b1; end
    else if (q < minv) begin r.re = 32'h8000_0000; r.ovf = 1'b1; end
    else                     r.re = q[31:0];
    q = sim >>> 33;
    if (q > maxv)      begin r.im = 32'h7FFF_FFFF; r.ovf = 1'b1; end
    else if (q < minv) begin r.im = 32'h8000_0000; r.ovf = 1'b1; end
    else                     r.im = q[31:0];
    return r;
  endfunction

  task automatic fill(input logic [31:0] ar, input logic [31:0] ai,
                      input logic [31:0] br, input logic [31:0] bi);
    for (int i = 0; i < 16; i++) begin
      va_re[i] = ar; va_im[i] = ai; vb_re[i] = br; vb_im[i] = bi;
    end
  endtask

  // Scoreboard: every out_valid must match the oldest expected result and last one cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        res_t e;
        check("out_valid_single_pulse", {63'b0, prev_ov}, 64'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got out_re %h with no run pending", out_re);
        end else begin
          e = exp_q.pop_front();
          check("sb_out_re", {32'b0, out_re}, {32'b0, e.re});
          check("sb_out_im", {32'b0, out_im}, {32'b0, e.im});
          check("sb_ovf",    {63'b0, ovf},    {63'b0, e.ovf});
        end
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  // One dot product; starts and ends on a falling edge with the engine idle.
  task automatic do_run(input int n_len, input bit cj, input bit gaps, input bit junk,
                        input bit poke_start, input int abort_at, input string tag,
                        output res_t got);
    int   hs, it, lat, guard;
    bit   took;
    res_t e;
    got = '{re: 32'h0, im: 32'h0, ovf: 1'b0};
    guard = 0;
    while (busy && guard < 50) begin @(negedge clk); guard++; end
    check({tag, "_idle_before_start"}, {63'b0, busy}, 64'd0);
    if (busy) return;

    start = 1'b1; len = n_len[3:0]; conj = cj;
    @(negedge clk);
    start = 1'b0; len = 4'hF - n_len[3:0]; conj = ~cj;
    check({tag, "_busy_after_start"}, {63'b0, busy}, 64'd1);
    check({tag, "_in_ready_load"}, {63'b0, in_ready}, 64'd1);
    check({tag, "_ovf_cleared"}, {63'b0, ovf}, 64'd0);
    check({tag, "_prev_re_held"}, {32'b0, out_re}, {32'b0, prev_exp.re});

    hs = 0; it = 0;
    while (hs <= n_len && it < 200) begin
      start = poke_start && (it == 1);
      if (gaps && (it % 2 == 1)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        a_re = va_re[hs]; a_im = va_im[hs]; b_re = vb_re[hs]; b_im = vb_im[hs];
      end
      took = in_valid && in_ready;
      @(negedge clk);
      if (took) hs++;
      it++;
      if (abort_at > 0 && hs == abort_at) begin
        start = 1'b0; in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check({tag, "_rst_in_ready"}, {63'b0, in_ready}, 64'd0);
        check({tag, "_rst_busy"}, {63'b0, busy}, 64'd0);
        check({tag, "_rst_out_valid"}, {63'b0, out_valid}, 64'd0);
        check({tag, "_rst_out_re"}, {32'b0, out_re}, 64'd0);
        check({tag, "_rst_out_im"}, {32'b0, out_im}, 64'd0);
        check({tag, "_rst_ovf"}, {63'b0, ovf}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_exp = '{re: 32'h0, im: 32'h0, ovf: 1'b0};
        return;
      end
    end
    start = 1'b0;
    check({tag, "_beats_accepted"}, hs, n_len + 1);
    check({tag, "_in_ready_drop"}, {63'b0, in_ready}, 64'd0);

    e = model(n_len, cj);
    exp_q.push_back(e);

    // Operands offered outside LOAD must not be consumed.
    in_valid = junk;
    a_re = 32'h7FFF_FFFF; a_im = 32'h8000_0000; b_re = 32'h7FFF_FFFF; b_im = 32'h1234_5678;

    lat = 1;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    check({tag, "_latency"}, lat, 4);
    if (out_valid) begin
      got.re = out_re; got.im = out_im; got.ovf = ovf;
      check({tag, "_busy_with_out_valid"}, {63'b0, busy}, 64'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_busy_falls"}, {63'b0, busy}, 64'd0);
    check({tag, "_out_re_held"}, {32'b0, out_re}, {32'b0, e.re});
    prev_exp = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    #23;
    check("reset_in_ready", {63'b0, in_ready}, 64'd0);
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_ovf", {63'b0, ovf}, 64'd0);
    check("reset_out_re", {32'b0, out_re}, 64'd0);
    check("reset_out_im", {32'b0, out_im}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // (1+j)(1+j) = 2j ; (1+j)conj(1+j) = 2
    fill(32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000);
    do_run(0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "t1", r);
    check("t1_lit_re", {32'b0, r.re}, {32'b0, 32'h0000_0000});
    check("t1_lit_im", {32'b0, r.im}, {32'b0, 32'h0040_0000});
    check("t1_lit_ovf", {63'b0, r.ovf}, 64'd0);
    do_run(0, 1'b1, 1'b0, 1'b0, 1'b0, -1, "t2", r);
    check("t2_lit_re", {32'b0, r.re}, {32'b0, 32'h0040_0000});
    check("t2_lit_im", {32'b0, r.im}, {32'b0, 32'h0000_0000});

    // Four beats of 0.5*2 with in_valid gaps and junk during drain = 4.0
    fill(32'h0400_0000, 32'h0, 32'h1000_0000, 32'h0);
    do_run(3, 1'b0, 1'b1, 1'b1, 1'b0, -1, "t3", r);
    check("t3_lit_re", {32'b0, r.re}, {32'b0, 32'h0080_0000});
    check("t3_lit_im", {32'b0, r.im}, {32'b0, 32'h0000_0000});

    fill(32'hF800_0000, 32'h0, 32'h0800_0000, 32'h0);
    do_run(0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "t4", r);
    check("t4_lit_re", {32'b0, r.re}, {32'b0, 32'hFFE0_0000});

    // Positive and negative saturation over the full 16-term vector
    fill(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    do_run(15, 1'b1, 1'b0, 1'b0, 1'b0, -1, "t5", r);
    check("t5_lit_re", {32'b0, r.re}, {32'b0, 32'h7FFF_FFFF});
    check("t5_lit_im", {32'b0, r.im}, {32'b0, 32'h0000_0000});
    check("t5_lit_ovf", {63'b0, r.ovf}, 64'd1);
    fill(32'h8000_0000, 32'h0, 32'h7FFF_FFFF, 32'h0);
    do_run(15, 1'b0, 1'b0, 1'b0, 1'b0, -1, "t6", r);
    check("t6_lit_re", {32'b0, r.re}, {32'b0, 32'h8000_0000});
    check("t6_lit_ovf", {63'b0, r.ovf}, 64'd1);

    // Mixed-sign conjugate run with a stray start during LOAD:
    // 3 * (1.5-0.5j)(0.5-1j) = 3 * (0.25-1.75j) = 0.75-5.25j
    fill(32'h0C00_0000, 32'hFC00_0000, 32'h0400_0000, 32'h0800_0000);
    do_run(2, 1'b1, 1'b0, 1'b0, 1'b1, -1, "t7", r);
    check("t7_lit_re", {32'b0, r.re}, {32'b0, 32'h0018_0000});
    check("t7_lit_im", {32'b0, r.im}, {32'b0, 32'hFF58_0000});

    // Reset after 2 of 4 beats, then a clean run must not see stale accumulation
    fill(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0100_0000);
    do_run(3, 1'b0, 1'b0, 1'b0, 1'b0, 2, "t8", r);
    fill(32'h0800_0000, 32'h0, 32'hF800_0000, 32'h0400_0000);
    do_run(1, 1'b0, 1'b0, 1'b0, 1'b0, -1, "t9", r);
    check("t9_lit_re", {32'b0, r.re}, {32'b0, 32'hFFC0_0000});
    check("t9_lit_im", {32'b0, r.im}, {32'b0, 32'h0020_0000});

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
